// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: drives one row low at a time, reads the columns,
// rejects multi-key presses and debounces into a registered one-hot key code.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  col_n,
    output logic [3:0]  row_n,
    output logic [11:0] key_onehot,
    output logic        key_valid,
    output logic        key_press
);

    localparam int          DIV_W   = $clog2(SCAN_DIV);
    localparam logic [3:0]  DB_MAX  = 4'(DEBOUNCE_CNT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // True when exactly one bit of the physical scan image is set.
    function automatic logic is_one_hot(input logic [11:0] v);
        return (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0);
    endfunction

    // Physical order is row*3+col; key code order is '0'..'9','*','#'.
    function automatic logic [11:0] map_keys(input logic [11:0] phys);
        return {phys[11], phys[9], phys[8:0], phys[10]};
    endfunction

    logic [2:0]       col_meta_r;
    logic [2:0]       col_sync_r;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       row_idx_r;
    logic [3:0]       row_n_r;
    logic [8:0]       partial_r;

    logic             sample_s;
    logic             scan_done_s;
    logic [11:0]      phys_s;
    logic [11:0]      result_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [11:0]      cand_r;
    logic [11:0]      cand_nxt_s;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_nxt_s;
    logic [3:0]       cnt_inc_s;
    logic [11:0]      key_r;
    logic [11:0]      key_nxt_s;
    logic             valid_r;
    logic             press_r;
    logic             press_nxt_s;

    // Two-flop synchroniser for the asynchronous column inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_meta_r <= 3'b111;
            col_sync_r <= 3'b111;
        end else begin
            col_meta_r <= col_n;
            col_sync_r <= col_meta_r;
        end
    end

    assign sample_s    = (div_r == DIV_LAST);
    assign scan_done_s = sample_s && (row_idx_r == 2'd3);

    // Row divider and rotating active-low row drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_r     <= '0;
            row_idx_r <= 2'd0;
            row_n_r   <= 4'b1110;
        end else if (sample_s) begin
            div_r     <= '0;
            row_idx_r <= row_idx_r + 2'd1;
            row_n_r   <= {row_n_r[2:0], row_n_r[3]};
        end else begin
            div_r     <= div_r + DIV_W'(1);
            row_idx_r <= row_idx_r;
            row_n_r   <= row_n_r;
        end
    end

    // Rows 0-2 are held here until the row-3 sample completes the image.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            partial_r <= 9'd0;
        end else if (sample_s) begin
            case (row_idx_r)
                2'd0:    partial_r[2:0] <= ~col_sync_r;
                2'd1:    partial_r[5:3] <= ~col_sync_r;
                2'd2:    partial_r[8:6] <= ~col_sync_r;
                default: partial_r      <= partial_r;
            endcase
        end else begin
            partial_r <= partial_r;
        end
    end

    assign phys_s    = {~col_sync_r, partial_r};
    assign result_s  = is_one_hot(phys_s) ? map_keys(phys_s) : 12'd0;
    assign cnt_inc_s = (cnt_r >= DB_MAX) ? DB_MAX : (cnt_r + 4'd1);

    // Debounce state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic, evaluated only on scan-result cycles.
    always_comb begin
        state_nxt_s = state_r;
        if (scan_done_s) begin
            case (state_r)
                IDLE: begin
                    if (result_s != 12'd0) state_nxt_s = PRESS_WAIT;
                    else                   state_nxt_s = IDLE;
                end
                PRESS_WAIT: begin
                    if (result_s == cand_r) begin
                        if (cnt_inc_s == DB_MAX) state_nxt_s = HELD;
                        else                     state_nxt_s = PRESS_WAIT;
                    end else if (result_s != 12'd0) begin
                        state_nxt_s = PRESS_WAIT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                HELD: begin
                    if (result_s == key_r) state_nxt_s = HELD;
                    else                   state_nxt_s = RELEASE_WAIT;
                end
                RELEASE_WAIT: begin
                    if (result_s == key_r)        state_nxt_s = HELD;
                    else if (cnt_inc_s == DB_MAX) state_nxt_s = IDLE;
                    else                          state_nxt_s = RELEASE_WAIT;
                end
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Next values of candidate, counter and outputs.
    always_comb begin
        cand_nxt_s  = cand_r;
        cnt_nxt_s   = cnt_r;
        key_nxt_s   = key_r;
        press_nxt_s = 1'b0;
        if (scan_done_s) begin
            case (state_r)
                IDLE: begin
                    key_nxt_s = 12'd0;
                    if (result_s != 12'd0) begin
                        cand_nxt_s = result_s;
                        cnt_nxt_s  = 4'd1;
                    end else begin
                        cand_nxt_s = 12'd0;
                        cnt_nxt_s  = 4'd0;
                    end
                end
                PRESS_WAIT: begin
                    if (result_s == cand_r) begin
                        cnt_nxt_s = cnt_inc_s;
                        if (cnt_inc_s == DB_MAX) begin
                            key_nxt_s   = cand_r;
                            press_nxt_s = 1'b1;
                        end else begin
                            key_nxt_s = key_r;
                        end
                    end else if (result_s != 12'd0) begin
                        cand_nxt_s = result_s;
                        cnt_nxt_s  = 4'd1;
                    end else begin
                        cand_nxt_s = 12'd0;
                        cnt_nxt_s  = 4'd0;
                    end
                end
                HELD: begin
                    if (result_s == key_r) cnt_nxt_s = cnt_r;
                    else                   cnt_nxt_s = 4'd1;
                end
                RELEASE_WAIT: begin
                    if (result_s == key_r) begin
                        cnt_nxt_s = DB_MAX;
                    end else if (cnt_inc_s == DB_MAX) begin
                        key_nxt_s  = 12'd0;
                        cand_nxt_s = 12'd0;
                        cnt_nxt_s  = 4'd0;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                default: begin
                    key_nxt_s  = 12'd0;
                    cand_nxt_s = 12'd0;
                    cnt_nxt_s  = 4'd0;
                end
            endcase
        end else begin
            press_nxt_s = 1'b0;
        end
    end

    // Registered debounce data and outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_r  <= 12'd0;
            cnt_r   <= 4'd0;
            key_r   <= 12'd0;
            valid_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            cand_r  <= cand_nxt_s;
            cnt_r   <= cnt_nxt_s;
            key_r   <= key_nxt_s;
            valid_r <= |key_nxt_s;
            press_r <= press_nxt_s;
        end
    end

    assign row_n      = row_n_r;
    assign key_onehot = key_r;
    assign key_valid  = valid_r;
    assign key_press  = press_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix
// (SCAN_DIV=4, DEBOUNCE_CNT=3, 16-cycle scans aligned to reset release).
module tb_keypad_scanner;

    logic        clk;
    logic        reset_n;
    logic [2:0]  col_n;
    logic [3:0]  row_n;
    logic [11:0] key_onehot;
    logic        key_valid;
    logic        key_press;

    logic [11:0] pressed;
    int          check_cnt;
    int          err_cnt;
    int          presses;
    logic [11:0] seen;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .col_n      (col_n),
        .row_n      (row_n),
        .key_onehot (key_onehot),
        .key_valid  (key_valid),
        .key_press  (key_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a held key at (r,c) pulls column c low while row r is driven.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) col_n = col_n & ~pressed[r*3 +: 3];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic run_scans(input int n, output int np, output logic [11:0] sn);
        np = 0;
        sn = 12'd0;
        repeat (16 * n) begin
            @(negedge clk);
            if (key_press) np++;
            sn = sn | key_onehot;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        check_cnt = 0;
        err_cnt   = 0;
        pressed   = 12'd0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_row", 32'(row_n), 32'(4'b1110));
        check("rst_key", 32'(key_onehot), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_press", 32'(key_press), 32'd0);

        // Row rotation, no key
        reset_n = 1'b1;
        check("row0", 32'(row_n), 32'(4'b1110));
        repeat (4) @(negedge clk);
        check("row1", 32'(row_n), 32'(4'b1101));
        repeat (4) @(negedge clk);
        check("row2", 32'(row_n), 32'(4'b1011));
        repeat (4) @(negedge clk);
        check("row3", 32'(row_n), 32'(4'b0111));
        repeat (4) @(negedge clk);
        check("row_wrap", 32'(row_n), 32'(4'b1110));
        check("idle_key", 32'(key_onehot), 32'd0);
        check("idle_press", 32'(key_press), 32'd0);

        // Clean press of '5' (row1, col1)
        pressed = 12'h010;
        run_scans(2, presses, seen);
        check("p5_early_key", 32'(seen), 32'd0);
        check("p5_early_press", 32'(presses), 32'd0);
        run_scans(1, presses, seen);
        check("p5_key", 32'(key_onehot), 32'h020);
        check("p5_valid", 32'(key_valid), 32'd1);
        check("p5_press", 32'(presses), 32'd1);
        run_scans(2, presses, seen);
        check("p5_hold_key", 32'(key_onehot), 32'h020);
        check("p5_hold_press", 32'(presses), 32'd0);
        pressed = 12'h000;
        run_scans(2, presses, seen);
        check("p5_rel_pending", 32'(key_onehot), 32'h020);
        run_scans(1, presses, seen);
        check("p5_released", 32'(key_onehot), 32'd0);
        check("p5_rel_valid", 32'(key_valid), 32'd0);
        check("p5_rel_press", 32'(presses), 32'd0);

        // Bounce: present, absent, then present for three scans
        pressed = 12'h010;
        run_scans(1, presses, seen);
        check("bnc_s1_key", 32'(seen), 32'd0);
        pressed = 12'h000;
        run_scans(1, presses, seen);
        check("bnc_s2_key", 32'(seen), 32'd0);
        pressed = 12'h010;
        run_scans(2, presses, seen);
        check("bnc_s4_key", 32'(seen), 32'd0);
        check("bnc_s4_press", 32'(presses), 32'd0);
        run_scans(1, presses, seen);
        check("bnc_s5_key", 32'(key_onehot), 32'h020);
        check("bnc_s5_press", 32'(presses), 32'd1);
        pressed = 12'h000;
        run_scans(3, presses, seen);
        check("bnc_rel_key", 32'(key_onehot), 32'd0);

        // Two keys '1' and '2' on row 0 together
        pressed = 12'h003;
        run_scans(6, presses, seen);
        check("multi_key", 32'(seen), 32'd0);
        check("multi_press", 32'(presses), 32'd0);
        pressed = 12'h000;
        run_scans(1, presses, seen);

        // '#' (row3, col2) with a one-scan release glitch
        pressed = 12'h800;
        run_scans(3, presses, seen);
        check("hash_key", 32'(key_onehot), 32'h800);
        check("hash_press", 32'(presses), 32'd1);
        pressed = 12'h000;
        run_scans(1, presses, seen);
        check("glitch_key", 32'(key_onehot), 32'h800);
        pressed = 12'h800;
        run_scans(2, presses, seen);
        check("glitch_back_key", 32'(key_onehot), 32'h800);
        check("glitch_no_press", 32'(presses), 32'd0);

        // True release of '#'
        pressed = 12'h000;
        run_scans(2, presses, seen);
        check("hash_rel2_key", 32'(key_onehot), 32'h800);
        run_scans(1, presses, seen);
        check("hash_rel3_key", 32'(key_onehot), 32'd0);
        check("hash_rel_press", 32'(presses), 32'd0);

        // Asynchronous reset while '#' is held
        pressed = 12'h800;
        run_scans(3, presses, seen);
        check("rehold_key", 32'(key_onehot), 32'h800);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_key", 32'(key_onehot), 32'd0);
        check("async_valid", 32'(key_valid), 32'd0);
        check("async_row", 32'(row_n), 32'(4'b1110));
        check("async_press", 32'(key_press), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x3 matrix keypad with a row-scan pattern and reads its columns.
- Debounces the scanned key and rejects multi-key presses.
- Presents the result as a 12-bit one-hot key code, held for as long as the key is held down.
- Produces the keypad input bus consumed by the door-lock controller: bit0..bit9 = digits '0'..'9', bit10 = '*', bit11 = '#', all-zero = no key.

Parameters:
SCAN_DIV, 1000, clock cycles each row stays active; legal range >=4 (covers sync latency plus settling).
DEBOUNCE_CNT, 4, consecutive identical full-scan results required to accept a press or a release; legal range 2..15.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
col_n  input  3  keypad columns, active-low (external pull-ups), asynchronous to clk
row_n  output  4  keypad row drives, active-low, exactly one bit low at any time
key_onehot  output  12  debounced one-hot key code, 0 when no key is accepted
key_valid  output  1  equals |key_onehot (registered)
key_press  output  1  one-cycle pulse when a new key is accepted

Behaviour:
- Reset values (asynchronous, immediate):
  - row_n=4'b1110; divider=0; row index=0.
  - key_onehot=0; key_valid=0; key_press=0.
  - FSM=IDLE; candidate=0; count=0; partial scan register=0.
  - Reset asserted mid-operation abandons any scan or debounce in progress.
- Synchroniser: col_n passes through a 2-flop synchroniser before use.
- Scan timing:
  - Divider counts 0..SCAN_DIV-1 per row.
  - At divider==SCAN_DIV-1 the synchronised columns are sampled for the current row.
  - On the next edge the row index advances 0→1→2→3→0 and row_n rotates 1110→1101→1011→0111→1110.
  - Full scan period = 4*SCAN_DIV cycles.
- Key map (row, col): r0=1,2,3; r1=4,5,6; r2=7,8,9; r3=*,0,#.
  - A pressed key reads as a low column bit.
- Scan result: formed at the row-3 sample cycle from the registered rows 0-2 samples plus the live row-3 sample.
  - Exactly one key down → its one-hot code.
  - Zero keys, or two or more keys down → 0 (ghost/multi-key rejection).
- Debounce FSM advances only on scan-result cycles; all outputs update on that same edge. States:
  - IDLE: key_onehot=0.
    - Result !=0 → PRESS_WAIT, candidate=result, count=1.
  - PRESS_WAIT:
    - Result==candidate → count+1; if count+1==DEBOUNCE_CNT → HELD, key_onehot=candidate, key_press=1 for one cycle.
    - Result nonzero and different → candidate=result, count=1.
    - Result 0 → IDLE.
  - HELD:
    - Result==key_onehot → stay.
    - Otherwise → RELEASE_WAIT, count=1.
  - RELEASE_WAIT:
    - Result==key_onehot → HELD, no new pulse.
    - Otherwise → count+1; if count+1==DEBOUNCE_CNT → IDLE, key_onehot=0.
    - A different key becomes acceptable only after returning to IDLE and re-debouncing from there.
- Latency: a key stable from scan k appears on key_onehot at the end of scan k+DEBOUNCE_CNT-1. Release latency is the same.
- key_press never asserts on a release, on a return from RELEASE_WAIT to HELD, or twice for one hold.
- key_onehot is always 0 or exactly one-hot.
- Counters saturate: count never exceeds DEBOUNCE_CNT.

Test Plan:
All cases use SCAN_DIV=4, DEBOUNCE_CNT=3, giving a scan period of 16 cycles.
- Reset/scan: release reset with no key → row_n=1110, then 1101 four cycles later, then 1011, 0111, 1110; key_onehot=0, key_press=0 throughout.
- Clean press '5' (col_n[1] low whenever row_n=1101) → key_onehot=12'h020 and key_valid=1 at the end of the 3rd full scan; key_press high exactly one cycle; key_onehot holds while pressed.
- Bounce: '5' seen in scan 1, absent in scan 2, present in scans 3-5 → key_onehot becomes 12'h020 only at the end of scan 5; no earlier key_press.
- Multi-key: '1' and '2' held together (row0, col_n=3'b100) for 6 scans → key_onehot stays 0, key_press never asserts.
- Release glitch: '#' held (12'h800 accepted), then one released scan, then pressed again → key_onehot stays 12'h800, no second key_press. True release → still 12'h800 after 2 released scans, 0 at the end of the 3rd.
- Reset mid-hold: assert reset_n=0 while 12'h800 is held → key_onehot=0, key_valid=0, row_n=1110 immediately, without waiting for clk.
